// File: rtl/hex_scan_scheduler.sv
// hex_scan_scheduler: one shared hex decoder scanned over HEX0..HEX5 from a 6-nibble buffer; HEX_LEADING_ZERO_BLANK_EN adds leading-zero blanking.
// Latency: digit latched 2 cycles after its scan tick; writes acked the cycle after accept, held off one cycle while the decoder reads.

module hex7seg (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = 7'h7F;
        case (nib_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end
endmodule

module hex_scan_scheduler #(
    parameter int SCAN_DIV      = 50000,
    parameter int SCROLL_FRAMES = 25
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       wr_req,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic       wr_ack,
    input  logic [5:0] blank_mask,
    input  logic       scroll_en,
    output logic       frame_done,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(SCROLL_FRAMES - 1);

    typedef enum logic [1:0] {S_WAIT, S_DECODE, S_LATCH} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      idx_q;
    logic [2:0]      off_q;
    logic [FW-1:0]   fcnt_q;
    logic [3:0]      nbuf_q [6];
    logic [6:0]      hex_q  [6];
    logic [6:0]      seg_q;
    logic            lz_q;
    logic            wr_ack_q;
    logic            frame_done_q;

    logic            tick;
    logic            wr_accept;
    logic            frame_end;
    logic [3:0]      sel_sum;
    logic [2:0]      sel_idx;
    logic [6:0]      dec_seg;
    logic            lz_blank;

    assign tick      = (cnt_q == CNT_LAST);
    assign wr_accept = wr_req && !wr_ack_q && (state_q != S_DECODE);
    assign frame_end = (state_q == S_LATCH) && (idx_q == 3'd5);

    // Display position plus scroll offset, folded back into 0..5.
    always_comb begin
        sel_sum = {1'b0, idx_q} + {1'b0, off_q};
        sel_idx = sel_sum[2:0];
        if (sel_sum >= 4'd6) begin
            sel_idx = 3'(sel_sum - 4'd6);
        end
    end

    hex7seg u_dec (
        .nib_i (nbuf_q[sel_idx]),
        .seg_o (dec_seg)
    );

`ifdef HEX_LEADING_ZERO_BLANK_EN
    logic [3:0] rot_sum;
    always_comb begin
        lz_blank = (idx_q != 3'd0);
        rot_sum  = '0;
        for (int j = 0; j < 6; j++) begin
            rot_sum = 4'(j) + {1'b0, off_q};
            if (rot_sum >= 4'd6) begin
                rot_sum = rot_sum - 4'd6;
            end
            if ((3'(j) >= idx_q) && (nbuf_q[rot_sum[2:0]] != 4'd0)) begin
                lz_blank = 1'b0;
            end
        end
    end
`else
    always_comb begin
        lz_blank = 1'b0;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:   if (tick) state_d = S_DECODE;
            S_DECODE: state_d = S_LATCH;
            S_LATCH:  state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q      <= S_WAIT;
            cnt_q        <= '0;
            idx_q        <= '0;
            off_q        <= '0;
            fcnt_q       <= '0;
            seg_q        <= 7'h7F;
            lz_q         <= 1'b0;
            wr_ack_q     <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                nbuf_q[i] <= 4'd0;
                hex_q[i]  <= 7'h7F;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= tick ? '0 : cnt_q + 1'b1;
            wr_ack_q     <= wr_accept;
            frame_done_q <= frame_end;

            // Addresses 6 and 7 are acknowledged but have no storage.
            if (wr_accept && (wr_addr < 3'd6)) begin
                nbuf_q[wr_addr] <= wr_data;
            end

            if (state_q == S_DECODE) begin
                seg_q <= dec_seg;
                lz_q  <= lz_blank;
            end

            if (state_q == S_LATCH) begin
                hex_q[idx_q] <= (blank_mask[idx_q] || lz_q) ? 7'h7F : seg_q;
                idx_q        <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
            end

            if (!scroll_en) begin
                off_q  <= '0;
                fcnt_q <= '0;
            end else if (frame_end) begin
                if (fcnt_q == FRM_LAST) begin
                    fcnt_q <= '0;
                    off_q  <= (off_q == 3'd5) ? 3'd0 : off_q + 3'd1;
                end else begin
                    fcnt_q <= fcnt_q + 1'b1;
                end
            end
        end
    end

    assign wr_ack     = wr_ack_q;
    assign frame_done = frame_done_q;
    assign HEX0       = hex_q[0];
    assign HEX1       = hex_q[1];
    assign HEX2       = hex_q[2];
    assign HEX3       = hex_q[3];
    assign HEX4       = hex_q[4];
    assign HEX5       = hex_q[5];
endmodule

// File: tb/tb_hex_scan_scheduler.sv
// Bench for hex_scan_scheduler: directed test-plan steps plus random traffic against a slot-timing reference model.

module tb_hex_scan_scheduler;
    localparam int SD = 4;
    localparam int SF = 1;

    logic       Clock;
    logic       Resetn;
    logic       wr_req;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ack;
    logic [5:0] blank_mask;
    logic       scroll_en;
    logic       frame_done;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [6:0] dut_hex [6];

    int checks = 0;
    int errors = 0;

    hex_scan_scheduler #(.SCAN_DIV(SD), .SCROLL_FRAMES(SF)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .blank_mask (blank_mask),
        .scroll_en  (scroll_en),
        .frame_done (frame_done),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5)
    );

    assign dut_hex[0] = HEX0;
    assign dut_hex[1] = HEX1;
    assign dut_hex[2] = HEX2;
    assign dut_hex[3] = HEX3;
    assign dut_hex[4] = HEX4;
    assign dut_hex[5] = HEX5;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    // Reference model: p counts posedges since reset release; slot edges follow from p alone.
    int         p = 0;
    bit         mvalid = 0;
    logic [3:0] mbuf [6];
    logic [6:0] mhex [6];
    logic       mack, mfd;
    int         moff, mfcnt, md, mr;
    logic [6:0] mpend;
    bit         mlz, dec_edge, lat_edge, acc, fend;

    always @(posedge Clock) begin
        if (!Resetn) begin
            p = 0; mack = 0; mfd = 0; moff = 0; mfcnt = 0; mpend = 7'h7F; mlz = 0;
            for (int i = 0; i < 6; i++) begin mbuf[i] = 4'd0; mhex[i] = 7'h7F; end
            mvalid = 1;
        end else begin
            p = p + 1;
            dec_edge = (p > SD) && (p % SD == 1);
            lat_edge = (p > SD + 1) && (p % SD == 2);
            acc = wr_req && !mack && !dec_edge;
            mack = acc;
            if (acc && wr_addr < 3'd6) mbuf[wr_addr] = wr_data;
            if (dec_edge) begin
                md = ((p - 1) / SD - 1) % 6;
                mr = (md + moff) % 6;
                mpend = seg_of(mbuf[mr]);
                mlz = 0;
`ifdef HEX_LEADING_ZERO_BLANK_EN
                mlz = (md != 0);
                for (int j = 0; j < 6; j++)
                    if (j >= md && mbuf[(j + moff) % 6] != 4'd0) mlz = 0;
`endif
            end
            mfd = 0;
            fend = 0;
            if (lat_edge) begin
                md = ((p - 2) / SD - 1) % 6;
                mhex[md] = (blank_mask[md] || mlz) ? 7'h7F : mpend;
                if (md == 5) begin mfd = 1; fend = 1; end
            end
            if (!scroll_en) begin
                moff = 0; mfcnt = 0;
            end else if (fend) begin
                mfcnt = mfcnt + 1;
                if (mfcnt == SF) begin mfcnt = 0; moff = (moff + 1) % 6; end
            end
        end
    end

    always @(negedge Clock) begin
        if (mvalid) begin
            chk("model_ack", wr_ack, mack);
            chk("model_frame_done", frame_done, mfd);
            for (int i = 0; i < 6; i++) chk($sformatf("model_hex%0d", i), dut_hex[i], mhex[i]);
        end
    end

    task automatic wait_fd();
        int n = 0;
        do begin @(negedge Clock); n++; end while (frame_done !== 1'b1 && n < 100);
        if (frame_done !== 1'b1) chk("frame_done_timeout", 0, 1);
    endtask

    // Return at the negedge whose following posedge has p % SD == ph.
    task automatic align(input int ph);
        int n = 0;
        while (!(((p + 1) % SD) == ph && (p + 1) > SD + 1) && n < 50) begin
            @(negedge Clock); n++;
        end
        if (n >= 50) chk("align_timeout", 0, 1);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [3:0] dt, output int lat);
        wr_req = 1'b1; wr_addr = a; wr_data = dt; lat = 0;
        do begin @(negedge Clock); lat++; end while (wr_ack !== 1'b1 && lat < 40);
        if (wr_ack !== 1'b1) chk("ack_timeout", 0, 1);
        // Request still high during the ack cycle must not be taken again.
        @(negedge Clock);
        chk("ack_one_cycle", wr_ack, 1'b0);
        wr_req = 1'b0;
    endtask

    int lat;

    initial begin
        Resetn = 1'b0; wr_req = 1'b0; wr_addr = 3'd0; wr_data = 4'd0;
        blank_mask = 6'd0; scroll_en = 1'b0;
        repeat (3) @(negedge Clock);
        for (int i = 0; i < 6; i++) chk($sformatf("reset_hex%0d", i), dut_hex[i], 7'h7F);
        chk("reset_ack", wr_ack, 1'b0);
        Resetn = 1'b1;

        repeat (5) @(negedge Clock);
        chk("hex0_before_first_latch", HEX0, 7'h7F);
        @(negedge Clock);
        chk("hex0_first_latch", HEX0, 7'h40);
        chk("hex1_not_yet", HEX1, 7'h7F);
        repeat (19) @(negedge Clock);
        chk("fd_before_end", frame_done, 1'b0);
        @(negedge Clock);
        chk("fd_at_26", frame_done, 1'b1);
        for (int i = 0; i < 6; i++) chk($sformatf("first_frame_hex%0d", i), dut_hex[i], 7'h40);

        do_write(3'd0, 4'h1, lat);
        do_write(3'd3, 4'hA, lat);
        do_write(3'd5, 4'hF, lat);
        wait_fd(); wait_fd();
        chk("wr_hex0", HEX0, 7'h79);
        chk("wr_hex3", HEX3, 7'h08);
        chk("wr_hex5", HEX5, 7'h0E);

        align(1);
        do_write(3'd2, 4'h3, lat);
        chk("deferred_ack_latency", lat, 2);
        align(3);
        do_write(3'd7, 4'h9, lat);
        chk("plain_ack_latency", lat, 1);
        wait_fd(); wait_fd();
        chk("defer_hex2", HEX2, 7'h30);
        chk("addr7_hex1", HEX1, 7'h40);
        chk("addr7_hex4", HEX4, 7'h40);

        do_write(3'd0, 4'h8, lat);
        blank_mask = 6'b000001;
        wait_fd(); wait_fd();
        chk("masked_hex0", HEX0, 7'h7F);
        blank_mask = 6'd0;
        wait_fd();
        chk("unmasked_hex0", HEX0, 7'h00);

        for (int i = 0; i < 6; i++) do_write(3'(i), 4'(i), lat);
        wait_fd();
        scroll_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            wait_fd();
            repeat (SD) @(negedge Clock);
            chk($sformatf("scroll_k%0d_hex0", k), HEX0, seg_of(4'(k % 6)));
        end
        scroll_en = 1'b0;
        wait_fd();
        repeat (SD) @(negedge Clock);
        chk("scroll_off_hex0", HEX0, 7'h40);

        repeat (7) @(negedge Clock);
        wr_req = 1'b1; wr_addr = 3'd2; wr_data = 4'h9; Resetn = 1'b0;
        @(negedge Clock);
        chk("rst_no_ack_a", wr_ack, 1'b0);
        @(negedge Clock);
        chk("rst_no_ack_b", wr_ack, 1'b0);
        for (int i = 0; i < 6; i++) chk($sformatf("rst_mid_hex%0d", i), dut_hex[i], 7'h7F);
        Resetn = 1'b1; wr_req = 1'b0;
        repeat (6) @(negedge Clock);
        chk("restart_hex0", HEX0, 7'h40);
        repeat (20) @(negedge Clock);
        chk("restart_fd", frame_done, 1'b1);
        for (int i = 0; i < 6; i++) chk($sformatf("restart_hex%0d", i), dut_hex[i], 7'h40);

        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 3))
                0, 1: do_write(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), lat);
                2: repeat ($urandom_range(0, 10)) @(negedge Clock);
                default: begin
                    blank_mask = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
                    scroll_en  = 1'($urandom);
                    @(negedge Clock);
                end
            endcase
        end
        repeat (30) @(negedge Clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
